// File: rtl/rom_boot_loader.sv
// Streams a program image into the platform ROM, then sequences the platform
// out of load mode through a settle cycle and a reset pulse into run mode.
module rom_boot_loader #(
  parameter int ROM_SIZE   = 16384,
  parameter int ADDR_W     = 14,
  parameter int RST_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] sw_addr,
  output logic [7:0]        sw_din,
  output logic              we_n,
  output logic              mode,
  output logic              plat_rst,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_SIZE - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAST,
    SETTLE,
    PRST,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              we_n_q, we_n_d;
  logic              mode_q, mode_d;
  logic              prst_q, prst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs;

  // byte_ready is the registered flag, so a byte is only taken while loading
  assign hs = byte_valid & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    ready_d = ready_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_n_d  = 1'b1;
    mode_d  = mode_q;
    prst_d  = prst_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          ready_d = 1'b1;
          mode_d  = 1'b1;
          prst_d  = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (hs) begin
          addr_d = cnt_q[ADDR_W-1:0];
          din_d  = byte_in;
          we_n_d = 1'b0;
          cnt_d  = cnt_q + 1'b1;
          // final byte: stop accepting now so the counter cannot pass ROM_SIZE
          if (cnt_q == CNT_LAST) begin
            state_d = LAST;
            ready_d = 1'b0;
          end
        end
      end
      LAST: begin
        state_d = SETTLE;
        mode_d  = 1'b0;
      end
      SETTLE: begin
        state_d = PRST;
        rc_d    = '0;
      end
      PRST: begin
        if (rc_q == RC_LAST) begin
          state_d = RUN;
          prst_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        mode_d  = 1'b0;
        prst_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rc_q    <= '0;
      ready_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      we_n_q  <= 1'b1;
      mode_q  <= 1'b0;
      prst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_n_q  <= we_n_d;
      mode_q  <= mode_d;
      prst_q  <= prst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign byte_ready = ready_q;
  assign sw_addr    = addr_q;
  assign sw_din     = din_q;
  assign we_n       = we_n_q;
  assign mode       = mode_q;
  assign plat_rst   = prst_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: three instances (4-byte ROM with 1 and 3 reset
// cycles, default 16384-byte ROM) checked against a timeline-based model.
module tb_rom_boot_loader;
  localparam int AW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s_ab, v_ab, s_c, v_c;
  logic [7:0] b_ab, b_c;

  logic          o_ready[3], o_we_n[3], o_mode[3], o_prst[3], o_busy[3], o_done[3];
  logic [AW-1:0] o_addr[3];
  logic [7:0]    o_din[3];

  rom_boot_loader #(.ROM_SIZE(4), .ADDR_W(AW), .RST_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(s_ab), .byte_in(b_ab), .byte_valid(v_ab),
    .byte_ready(o_ready[0]), .sw_addr(o_addr[0]), .sw_din(o_din[0]), .we_n(o_we_n[0]),
    .mode(o_mode[0]), .plat_rst(o_prst[0]), .busy(o_busy[0]), .done(o_done[0]));

  rom_boot_loader #(.ROM_SIZE(4), .ADDR_W(AW), .RST_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(s_ab), .byte_in(b_ab), .byte_valid(v_ab),
    .byte_ready(o_ready[1]), .sw_addr(o_addr[1]), .sw_din(o_din[1]), .we_n(o_we_n[1]),
    .mode(o_mode[1]), .plat_rst(o_prst[1]), .busy(o_busy[1]), .done(o_done[1]));

  rom_boot_loader dut_c (
    .clk(clk), .rst(rst), .start(s_c), .byte_in(b_c), .byte_valid(v_c),
    .byte_ready(o_ready[2]), .sw_addr(o_addr[2]), .sw_din(o_din[2]), .we_n(o_we_n[2]),
    .mode(o_mode[2]), .plat_rst(o_prst[2]), .busy(o_busy[2]), .done(o_done[2]));

  int    rom[3] = '{4, 4, 16384};
  int    rc[3]  = '{1, 3, 1};
  string nm[3]  = '{"A", "B", "C"};

  // model: m_t counts cycles since the final write cycle (-1 = none yet)
  bit            m_idle[3], m_load[3], m_wr[3], hs_seen[3], need_first[3];
  int            m_n[3], m_t[3];
  logic [AW-1:0] m_addr[3];
  logic [7:0]    m_data[3];
  logic [7:0]    sent[3][16384];
  logic [7:0]    img[3][16384];
  int            wc[3][16384];
  int            last_addr[3], first_addr[3], gap[3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_run(input int i);
    return !m_idle[i] && !m_load[i] && (m_t[i] >= 2 + rc[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_idle[i] = 1; m_load[i] = 0; m_wr[i] = 0; hs_seen[i] = 0;
      m_n[i] = 0; m_t[i] = -1; m_addr[i] = '0; m_data[i] = '0;
    end
  endtask

  task automatic model_step();
    logic st, v;
    logic [7:0] b;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      st = (i < 2) ? s_ab : s_c;
      v  = (i < 2) ? v_ab : v_c;
      b  = (i < 2) ? b_ab : b_c;
      hs_seen[i] = 0;
      if (m_idle[i] || m_run(i)) begin
        if (st) begin
          m_idle[i] = 0; m_load[i] = 1; m_n[i] = 0; m_t[i] = -1; m_wr[i] = 0;
          need_first[i] = 1;
          for (int a = 0; a < rom[i]; a++) wc[i][a] = 0;
        end
      end else if (m_load[i]) begin
        m_wr[i] = v;
        if (v) begin
          hs_seen[i] = 1;
          m_addr[i] = AW'(m_n[i]);
          m_data[i] = b;
          sent[i][m_n[i]] = b;
          m_n[i]++;
          if (m_n[i] == rom[i]) begin
            m_load[i] = 0;
            m_t[i] = 0;
          end
        end
      end else begin
        m_t[i]++;
        m_wr[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    bit e_busy, e_done, e_mode;
    for (int i = 0; i < 3; i++) begin
      e_busy = m_load[i] || (m_t[i] >= 0 && m_t[i] < 2 + rc[i]);
      e_done = m_run(i);
      e_mode = m_load[i] || (m_t[i] == 0);
      chk({"byte_ready_", nm[i]}, 32'(o_ready[i]), 32'(m_load[i]));
      chk({"busy_", nm[i]},       32'(o_busy[i]),  32'(e_busy));
      chk({"done_", nm[i]},       32'(o_done[i]),  32'(e_done));
      chk({"mode_", nm[i]},       32'(o_mode[i]),  32'(e_mode));
      chk({"plat_rst_", nm[i]},   32'(o_prst[i]),  32'(!e_done));
      chk({"we_n_", nm[i]},       32'(o_we_n[i]),  32'(!m_wr[i]));
      chk({"sw_addr_", nm[i]},    32'(o_addr[i]),  32'(m_addr[i]));
      chk({"sw_din_", nm[i]},     32'(o_din[i]),   32'(m_data[i]));
      if (o_we_n[i] === 1'b0) begin
        img[i][int'(o_addr[i])] = o_din[i];
        wc[i][int'(o_addr[i])]++;
        last_addr[i] = int'(o_addr[i]);
        if (need_first[i]) begin
          first_addr[i] = int'(o_addr[i]);
          need_first[i] = 0;
        end
        gap[i] = 0;
      end else if (o_prst[i] === 1'b1 && o_mode[i] === 1'b0) begin
        gap[i]++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic check_image(input int i);
    for (int a = 0; a < rom[i]; a++) begin
      chk({"write_count_", nm[i]}, 32'(wc[i][a]), 32'd1);
      chk({"image_", nm[i]},       32'(img[i][a]), 32'(sent[i][a]));
    end
  endtask

  task automatic wait_ab_done(input int budget);
    int k = 0;
    while (!(o_done[0] === 1'b1 && o_done[1] === 1'b1) && k < budget) begin
      b_ab = 8'($urandom);
      cyc();
      k++;
    end
    chk("done_A_reached", 32'(o_done[0]), 32'd1);
    chk("done_B_reached", 32'(o_done[1]), 32'd1);
  endtask

  logic [7:0] q[4];
  int         idx, guard;

  initial begin
    q[0] = 8'h11; q[1] = 8'h22; q[2] = 8'h33; q[3] = 8'h44;
    for (int i = 0; i < 3; i++) begin
      last_addr[i] = -1; first_addr[i] = -1; gap[i] = 0; need_first[i] = 0;
    end
    rst = 1'b1; s_ab = 0; v_ab = 0; b_ab = 0; s_c = 0; v_c = 0; b_c = 0;
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();

    // fixed four-byte load, valid held high
    s_ab = 1'b1;
    cyc();
    s_ab = 1'b0; v_ab = 1'b1; idx = 0; b_ab = q[0]; guard = 0;
    while (idx < 4 && guard < 20) begin
      cyc();
      if (hs_seen[0]) idx++;
      b_ab = (idx < 4) ? q[idx] : 8'($urandom);
      guard++;
    end
    chk("bytes_taken_A", 32'(idx), 32'd4);
    wait_ab_done(40);
    chk("rst_gap_A", 32'(gap[0]), 32'd2);
    chk("rst_gap_B", 32'(gap[1]), 32'd4);
    chk("last_addr_A", 32'(last_addr[0]), 32'd3);
    for (int a = 0; a < 4; a++) chk("fixed_data_A", 32'(img[0][a]), 32'(q[a]));
    check_image(0);
    check_image(1);

    // reload from RUN with valid toggling 1,0,1,0
    s_ab = 1'b1;
    cyc();
    s_ab = 1'b0;
    guard = 0;
    while (!(o_done[0] === 1'b1 && o_done[1] === 1'b1) && guard < 60) begin
      v_ab = (guard % 2 == 0);
      b_ab = 8'($urandom);
      cyc();
      guard++;
    end
    chk("toggle_done_A", 32'(o_done[0]), 32'd1);
    chk("toggle_done_B", 32'(o_done[1]), 32'd1);
    chk("toggle_first_A", 32'(first_addr[0]), 32'd0);
    check_image(0);
    check_image(1);

    // start held high through a load and into RUN
    s_ab = 1'b1;
    cyc();
    guard = 0;
    while (o_done[0] !== 1'b1 && guard < 80) begin
      v_ab = ($urandom_range(0, 3) != 0);
      b_ab = 8'($urandom);
      cyc();
      guard++;
    end
    chk("held_start_run_A", 32'(o_done[0]), 32'd1);
    cyc();
    chk("reload_done_fall_A", 32'(o_done[0]), 32'd0);
    chk("reload_prst_rise_A", 32'(o_prst[0]), 32'd1);
    s_ab = 1'b0;
    guard = 0;
    while (!(o_done[0] === 1'b1 && o_done[1] === 1'b1) && guard < 100) begin
      v_ab = ($urandom_range(0, 3) != 0);
      b_ab = 8'($urandom);
      cyc();
      guard++;
    end
    chk("reload_done_A", 32'(o_done[0]), 32'd1);
    chk("reload_first_A", 32'(first_addr[0]), 32'd0);
    check_image(0);

    // reset after two bytes, then restart
    s_ab = 1'b1;
    cyc();
    s_ab = 1'b0; v_ab = 1'b1; guard = 0;
    while (m_n[0] < 2 && guard < 10) begin
      b_ab = 8'($urandom);
      cyc();
      guard++;
    end
    chk("partial_bytes_A", 32'(m_n[0]), 32'd2);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (2) cyc();
    rst = 1'b0;
    s_ab = 1'b1;
    cyc();
    s_ab = 1'b0;
    wait_ab_done(60);
    chk("restart_first_A", 32'(first_addr[0]), 32'd0);
    chk("restart_first_B", 32'(first_addr[1]), 32'd0);
    check_image(0);

    // full-size image on the default instance
    s_c = 1'b1;
    cyc();
    s_c = 1'b0; guard = 0;
    while (o_done[2] !== 1'b1 && guard < 30000) begin
      v_c = ($urandom_range(0, 7) != 0);
      b_c = 8'($urandom);
      cyc();
      guard++;
    end
    chk("full_done_C", 32'(o_done[2]), 32'd1);
    chk("full_last_addr_C", 32'(last_addr[2]), 32'd16383);
    v_c = 1'b1;
    repeat (5) begin
      b_c = 8'($urandom);
      cyc();
    end
    chk("full_still_done_C", 32'(o_done[2]), 32'd1);
    check_image(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
